// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters gated by a pixel enable, registered
// sync/de/strobe decode with programmable polarity and an optional OUT_DELAY-stage delay
// line that aligns sync with downstream pixel latency.
// Optional feature: define VTG_LINE_IRQ_EN to add irq_line_i / line_irq_o.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned OUT_DELAY = 0,
  parameter int unsigned XW        = 10,
  parameter int unsigned YW        = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          pix_ce_i,
`ifdef VTG_LINE_IRQ_EN
  input  logic [YW-1:0] irq_line_i,
  output logic          line_irq_o,
`endif
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_start_o,
  output logic          line_start_o
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOT - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_FIRST = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOT - 1);
  localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_FIRST = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Bit positions inside one delay-line word; sync bits hold the "active" level, not the pin.
  localparam int unsigned BHs = 0;
  localparam int unsigned BVs = 1;
  localparam int unsigned BDe = 2;
  localparam int unsigned BFs = 3;
  localparam int unsigned BLs = 4;
`ifdef VTG_LINE_IRQ_EN
  localparam int unsigned BIrq = 5;
  localparam int unsigned PW   = 6;
`else
  localparam int unsigned PW   = 5;
`endif

  logic [XW-1:0] hcount_q, hcount_d;
  logic [YW-1:0] vcount_q, vcount_d;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          ce_q;
  logic [PW-1:0] dec;
  logic [PW-1:0] pipe_q [OUT_DELAY+1];

  // Next position: advance on pix_ce, wrap h at H_TOT-1 and v on the h wrap.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_ce_i) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + YW'(1);
      end else begin
        hcount_d = hcount_q + XW'(1);
      end
    end
  end

  // Decode of the position currently being issued.
  always_comb begin
    dec      = '0;
    dec[BHs] = (hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST);
    dec[BVs] = (vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST);
    dec[BDe] = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    dec[BFs] = (hcount_q == '0) && (vcount_q == '0);
    dec[BLs] = (hcount_q == '0);
`ifdef VTG_LINE_IRQ_EN
    // irq_line_i >= V_TOT can never equal vcount, so it never fires.
    dec[BIrq] = (hcount_q == H_ACT) && (vcount_q == irq_line_i);
`endif
  end

  // Counters and undelayed x/y.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcount_q <= '0;
      vcount_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (pix_ce_i) begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      x_q      <= hcount_q;
      y_q      <= vcount_q;
    end
  end

  // Decode register plus OUT_DELAY stages, all advancing only on enabled cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i <= int'(OUT_DELAY); i++) begin
        pipe_q[i] <= '0;
      end
    end else if (pix_ce_i) begin
      pipe_q[0] <= dec;
      for (int i = 1; i <= int'(OUT_DELAY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Remembers whether the last edge advanced the pipe; strobes are only valid for that clk.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ce_q <= 1'b0;
    end else begin
      ce_q <= pix_ce_i;
    end
  end

  assign hsync_o       = pipe_q[OUT_DELAY][BHs] ^ ~HS_POL;
  assign vsync_o       = pipe_q[OUT_DELAY][BVs] ^ ~VS_POL;
  assign de_o          = pipe_q[OUT_DELAY][BDe];
  assign frame_start_o = pipe_q[OUT_DELAY][BFs] & ce_q;
  assign line_start_o  = pipe_q[OUT_DELAY][BLs] & ce_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
`ifdef VTG_LINE_IRQ_EN
  assign line_irq_o    = pipe_q[OUT_DELAY][BIrq] & ce_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster (15x10 total, 8x5 visible). Two instances:
// active-low syncs with no delay, and active-high syncs with three delay stages.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 5, VF = 1, VSW = 2, VB = 2;
  localparam int H_TOT = HA + HF + HSW + HB;
  localparam int V_TOT = VA + VF + VSW + VB;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int D1 = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       hs0, vs0, de0, fs0, ls0, hs1, vs1, de1, fs1, ls1;
  logic [3:0] x0, y0, x1, y1;
`ifdef VTG_LINE_IRQ_EN
  logic [3:0] irq_line;
  logic       irq0, irq1;
`endif

  int total = 0;
  int bad = 0;
  int k = 0;        // enabled edges since reset release
  bit last_ce = 0;  // previous edge was an enabled, out-of-reset edge
  int irq_val = 3;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .OUT_DELAY(0), .XW(4), .YW(4)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .pix_ce_i(ce),
`ifdef VTG_LINE_IRQ_EN
    .irq_line_i(irq_line), .line_irq_o(irq0),
`endif
    .hsync_o(hs0), .vsync_o(vs0), .de_o(de0), .x_o(x0), .y_o(y0),
    .frame_start_o(fs0), .line_start_o(ls0)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .OUT_DELAY(D1), .XW(4), .YW(4)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .pix_ce_i(ce),
`ifdef VTG_LINE_IRQ_EN
    .irq_line_i(irq_line), .line_irq_o(irq1),
`endif
    .hsync_o(hs1), .vsync_o(vs1), .de_o(de1), .x_o(x1), .y_o(y1),
    .frame_start_o(fs1), .line_start_o(ls1)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t k=%0d)", name, act, exp, $time, k);
    end
  endtask

  // Expected {irq, ls, fs, de, vs, hs} pins for an instance with delay d and given polarities.
  // The word seen now belongs to the (k-1-d)-th issued position; positions are raster order.
  function automatic logic [5:0] model(input int d, input bit hp, input bit vp);
    int idx, p, px, py;
    logic [5:0] r;
    bit act_h, act_v;
    idx = k - 1 - d;
    if (idx < 0) begin
      r = {4'b0000, ~vp, ~hp};
      return r;
    end
    p = idx % FRAME;
    px = p % H_TOT;
    py = p / H_TOT;
    act_h = (px >= HA + HF) && (px < HA + HF + HSW);
    act_v = (py >= VA + VF) && (py < VA + VF + VSW);
    r[0] = act_h ? hp : ~hp;
    r[1] = act_v ? vp : ~vp;
    r[2] = (px < HA) && (py < VA);
    r[3] = last_ce && (px == 0) && (py == 0);
    r[4] = last_ce && (px == 0);
    r[5] = last_ce && (px == HA) && (py == irq_val);
    return r;
  endfunction

  task automatic check_all();
    int ex, ey;
    logic [5:0] m0, m1;
    ex = (k >= 1) ? ((k - 1) % FRAME) % H_TOT : 0;
    ey = (k >= 1) ? ((k - 1) % FRAME) / H_TOT : 0;
    m0 = model(0, 1'b0, 1'b0);
    m1 = model(D1, 1'b1, 1'b1);
    chk("x0", int'(x0), ex);
    chk("y0", int'(y0), ey);
    chk("x1", int'(x1), ex);
    chk("y1", int'(y1), ey);
    chk("outs0", int'({ls0, fs0, de0, vs0, hs0}), int'(m0[4:0]));
    chk("outs1", int'({ls1, fs1, de1, vs1, hs1}), int'(m1[4:0]));
`ifdef VTG_LINE_IRQ_EN
    chk("irq0", int'(irq0), int'(m0[5]));
    chk("irq1", int'(irq1), int'(m1[5]));
`endif
  endtask

  // One clock: drive pix_ce, update the model for the edge, sample 1 time unit later.
  task automatic step(input bit c);
    ce = c;
    @(posedge clk);
    if (rst_n && c) k++;
    last_ce = rst_n && c;
    #1;
    check_all();
  endtask

  // Asynchronous reset: outputs must clear before the next clock edge.
  task automatic pulse_reset(input int new_irq);
    #2;
    rst_n = 1'b0;
    irq_val = new_irq;
`ifdef VTG_LINE_IRQ_EN
    irq_line = 4'(new_irq);
`endif
    #1;
    k = 0;
    last_ce = 0;
    check_all();
    step(1'b1);
    step(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         edges;
    int         ex;
    int         ey;
    logic [4:0] outs;  // {ls, fs, de, vsync, hsync} pins of the active-low, undelayed instance
  } vec_t;

  vec_t vecs[13];
  int   cnt;
  int   first_de;

  initial begin
    vecs[0]  = '{1,   0,  0, 5'b11111};
    vecs[1]  = '{8,   7,  0, 5'b00111};
    vecs[2]  = '{9,   8,  0, 5'b00011};
    vecs[3]  = '{11,  10, 0, 5'b00010};
    vecs[4]  = '{13,  12, 0, 5'b00010};
    vecs[5]  = '{14,  13, 0, 5'b00011};
    vecs[6]  = '{16,  0,  1, 5'b10111};
    vecs[7]  = '{76,  0,  5, 5'b10011};
    vecs[8]  = '{91,  0,  6, 5'b10001};
    vecs[9]  = '{120, 14, 7, 5'b00001};
    vecs[10] = '{121, 0,  8, 5'b10011};
    vecs[11] = '{150, 14, 9, 5'b00011};
    vecs[12] = '{151, 0,  0, 5'b11111};

    rst_n = 1'b0;
    ce = 1'b0;
`ifdef VTG_LINE_IRQ_EN
    irq_line = 4'(irq_val);
`endif
    #1;
    check_all();
    step(1'b1);
    step(1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Boundary table with pix_ce held high.
    foreach (vecs[i]) begin
      for (int n = 0; n < 200 && k < vecs[i].edges; n++) step(1'b1);
      chk("tbl_x", int'(x0), vecs[i].ex);
      chk("tbl_y", int'(y0), vecs[i].ey);
      chk("tbl_outs", int'({ls0, fs0, de0, vs0, hs0}), int'(vecs[i].outs));
    end

    // One full frame of de.
    cnt = 0;
    for (int n = 0; n < FRAME; n++) begin
      step(1'b1);
      if (de0) cnt++;
    end
    chk("de_per_frame", cnt, HA * VA);

    // Delayed instance: de first rises D1 enabled cycles after position (0,0) is issued.
    pulse_reset(irq_val);
    first_de = -1;
    for (int n = 0; n < 20 && first_de < 0; n++) begin
      step(1'b1);
      if (de1) first_de = k;
    end
    chk("de1_first_edge", first_de, 1 + D1);
    chk("de1_first_x", int'(x1), D1);

`ifdef VTG_LINE_IRQ_EN
    cnt = 0;
    for (int n = 0; n < FRAME; n++) begin
      step(1'b1);
      if (irq0) cnt++;
    end
    chk("irq_per_frame", cnt, 1);
    pulse_reset(12);
    cnt = 0;
    for (int n = 0; n < FRAME + 5; n++) begin
      step(1'b1);
      if (irq0 || irq1) cnt++;
    end
    chk("irq_out_of_range", cnt, 0);
    pulse_reset(3);
`endif

    // Alternating enable: periods double, strobes stay one clock.
    for (int n = 0; n < 2 * FRAME; n++) step(n[0] == 1'b0);

    // Random enable with random mid-frame async resets.
    for (int seg = 0; seg < 3; seg++) begin
      int len;
      len = 200 + int'($urandom_range(0, 200));
      for (int n = 0; n < len; n++) step($urandom_range(0, 3) != 0);
      pulse_reset(int'($urandom_range(0, V_TOT + 2)));
    end
    for (int n = 0; n < 300; n++) step($urandom_range(0, 1) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
